// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Drives one MAC unit through a stride-1, valid-padding 2-D convolution.
//   Every output window gets KSIZE*KSIZE tap reads from the image and filter
//   buffers. The returned operands go to the MAC with macEnable, and the
//   final tap is flagged with oneConvDone. The MAC result is then captured
//   into a single-entry valid/ready output register.
//
// Optional feature (compile-time macro CONV_RELU_EN):
//   defined   -> captured result is max(mac_output, 0)
//   undefined -> mac_output is captured unmodified
//   Timing is the same either way.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               one-cycle pulse, starts a full pass when idle
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   img_rd_en/img_addr  image buffer read; img_rdata valid one cycle later
//   flt_rd_en/flt_addr  filter buffer read; flt_rdata valid one cycle later
//   macEnable           operand valid to the MAC
//   oneConvDone         last-tap marker to the MAC
//   imageData_out       img_rdata while macEnable, else 0
//   filterData_out      flt_rdata while macEnable, else 0
//   mac_output          MAC result, sampled only while oneConvDone
//   result_valid/ready  output handshake; transfer when both are high
//   result_data/addr    captured result and its output pixel index
//
// Handshake: a result transfers on every rising clk edge where
//   result_valid && result_ready. result_valid stays high and
//   result_data/result_addr stay stable until that transfer happens.
module conv_window_sequencer #(
  parameter int IMG_W           = 28,
  parameter int IMG_H           = 28,
  parameter int KSIZE           = 3,
  parameter int dataWidth       = 16,
  parameter int filterDataWidth = 4,
  parameter int IMG_AW          = 10,
  parameter int FLT_AW          = 6,
  parameter int OUT_AW          = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       img_rd_en,
  output logic [IMG_AW-1:0]          img_addr,
  input  logic [dataWidth-1:0]       img_rdata,
  output logic                       flt_rd_en,
  output logic [FLT_AW-1:0]          flt_addr,
  input  logic [filterDataWidth-1:0] flt_rdata,
  output logic                       macEnable,
  output logic                       oneConvDone,
  output logic [dataWidth-1:0]       imageData_out,
  output logic [filterDataWidth-1:0] filterData_out,
  input  logic [dataWidth-1:0]       mac_output,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [dataWidth-1:0]       result_data,
  output logic [OUT_AW-1:0]          result_addr
);

  localparam int OUT_W = IMG_W - KSIZE + 1;
  localparam int OUT_H = IMG_H - KSIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SLOT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]           kx, ky;
  logic [IMG_AW-1:0]    col, row;
  logic [OUT_AW-1:0]    win;
  logic                 rd_en, last_tap, last_win, slot_free;
  logic                 rd_en_d, last_d;
  logic [OUT_AW-1:0]    win_d;
  logic [dataWidth-1:0] captured;

  assign last_tap = (kx == 3'(KSIZE - 1)) && (ky == 3'(KSIZE - 1));
  assign last_win = (col == IMG_AW'(OUT_W - 1)) && (row == IMG_AW'(OUT_H - 1));

  // A capture still sitting in the data stage counts as an occupied slot.
  // Without this, the next window could start while the previous result is
  // still in flight and then overwrite it if result_ready stays low.
  assign slot_free = !last_d && (!result_valid || result_ready);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      S_IDLE:      if (start) state_next = S_WAIT_SLOT;
      S_WAIT_SLOT: if (slot_free) state_next = S_RUN;
      S_RUN: begin
        rd_en = 1'b1;
        if (last_tap) state_next = last_win ? S_DRAIN : S_WAIT_SLOT;
      end
      S_DRAIN:     state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign img_rd_en = rd_en;
  assign flt_rd_en = rd_en;

  // Addresses are held at zero whenever no tap is being issued.
  assign img_addr = rd_en ? (row + IMG_AW'(ky)) * IMG_AW'(IMG_W) + col + IMG_AW'(kx)
                          : '0;
  assign flt_addr = rd_en ? FLT_AW'(ky) * FLT_AW'(KSIZE) + FLT_AW'(kx) : '0;

  // ---------------- tap / window counters ----------------
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      kx  <= '0;
      ky  <= '0;
      col <= '0;
      row <= '0;
      win <= '0;
    end else if (rd_en) begin
      if (last_tap) begin
        kx  <= '0;
        ky  <= '0;
        win <= win + OUT_AW'(1);
        if (col == IMG_AW'(OUT_W - 1)) begin
          col <= '0;
          row <= last_win ? '0 : row + IMG_AW'(1);
        end else begin
          col <= col + IMG_AW'(1);
        end
      end else if (kx == 3'(KSIZE - 1)) begin
        kx <= '0;
        ky <= ky + 3'd1;
      end else begin
        kx <= kx + 3'd1;
      end
    end
  end

  // ---------------- data stage (aligned with buffer read latency) -------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_d <= 1'b0;
      last_d  <= 1'b0;
      win_d   <= '0;
    end else begin
      rd_en_d <= rd_en;
      last_d  <= rd_en && last_tap;
      if (rd_en) win_d <= win;
    end
  end

  assign macEnable      = rd_en_d;
  assign oneConvDone    = last_d;
  assign imageData_out  = macEnable ? img_rdata : '0;
  assign filterData_out = macEnable ? flt_rdata : '0;

  // ---------------- result register ----------------
  always_comb begin
`ifdef CONV_RELU_EN
    captured = mac_output[dataWidth-1] ? '0 : mac_output;
`else
    captured = mac_output;
`endif
  end

  // A capture takes priority over a handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_data  <= '0;
      result_addr  <= '0;
    end else if (oneConvDone) begin
      result_valid <= 1'b1;
      result_data  <= captured;
      result_addr  <= win_d;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
module tb_conv_window_sequencer;
  localparam int DW = 16;
  localparam int FW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- DUT A: 4x4 image, KSIZE=3 ----------------
  logic start = 1'b0;
  logic result_ready = 1'b1;
  logic busy, done, img_rd_en, flt_rd_en, mac_en, one_done, result_valid;
  logic [9:0] img_addr, result_addr;
  logic [5:0] flt_addr;
  logic [DW-1:0] img_rdata, img_dout, mac_output, result_data;
  logic [FW-1:0] flt_rdata, flt_dout;

  conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .KSIZE(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
    .flt_rd_en(flt_rd_en), .flt_addr(flt_addr), .flt_rdata(flt_rdata),
    .macEnable(mac_en), .oneConvDone(one_done),
    .imageData_out(img_dout), .filterData_out(flt_dout),
    .mac_output(mac_output), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data),
    .result_addr(result_addr)
  );

  logic [DW-1:0] img_mem [16];
  logic [FW-1:0] flt_mem [9];
  always @(posedge clk) begin
    img_rdata <= img_rd_en ? img_mem[img_addr[3:0]] : 16'h5A5A;
    flt_rdata <= flt_rd_en ? flt_mem[flt_addr[3:0]] : 4'h5;
  end

  // Behavioural MAC: accumulates while enabled, clears on a gap or after the
  // last tap, drives its sum only while oneConvDone is high.
  logic signed [DW-1:0] acc, prod, fext;
  assign fext = {{(DW-FW){flt_dout[FW-1]}}, flt_dout};
  assign prod = $signed(img_dout) * fext;
  always @(posedge clk) begin
    if (reset || !mac_en || one_done) acc <= '0;
    else acc <= acc + prod;
  end
  assign mac_output = one_done ? acc + prod : 16'h7A5C;

  logic [68:0] all_out;
  assign all_out = {busy, done, img_rd_en, flt_rd_en, mac_en, one_done, result_valid,
                    result_data, result_addr, img_addr, flt_addr, img_dout, flt_dout};

  // ---------------- DUT B: 3x3 image, KSIZE=1 ----------------
  logic start1 = 1'b0;
  logic ready1 = 1'b1;
  logic busy1, done1, img_rd_en1, flt_rd_en1, mac_en1, one_done1, result_valid1;
  logic [9:0] img_addr1, result_addr1;
  logic [5:0] flt_addr1;
  logic [DW-1:0] img_rdata1, img_dout1, mac_output1, result_data1;
  logic [FW-1:0] flt_rdata1, flt_dout1;

  conv_window_sequencer #(.IMG_W(3), .IMG_H(3), .KSIZE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .img_rd_en(img_rd_en1), .img_addr(img_addr1), .img_rdata(img_rdata1),
    .flt_rd_en(flt_rd_en1), .flt_addr(flt_addr1), .flt_rdata(flt_rdata1),
    .macEnable(mac_en1), .oneConvDone(one_done1),
    .imageData_out(img_dout1), .filterData_out(flt_dout1),
    .mac_output(mac_output1), .result_valid(result_valid1),
    .result_ready(ready1), .result_data(result_data1),
    .result_addr(result_addr1)
  );

  logic [DW-1:0] img1_mem [9];
  logic [FW-1:0] flt1_val = 4'd2;
  always @(posedge clk) begin
    img_rdata1 <= img_rd_en1 ? img1_mem[img_addr1[3:0]] : 16'h5A5A;
    flt_rdata1 <= flt_rd_en1 ? flt1_val : 4'h5;
  end
  logic signed [DW-1:0] acc1, prod1, fext1;
  assign fext1 = {{(DW-FW){flt_dout1[FW-1]}}, flt_dout1};
  assign prod1 = $signed(img_dout1) * fext1;
  always @(posedge clk) begin
    if (reset || !mac_en1 || one_done1) acc1 <= '0;
    else acc1 <= acc1 + prod1;
  end
  assign mac_output1 = one_done1 ? acc1 + prod1 : 16'h7A5C;

  // ---------------- reference model / scoreboard ----------------
  int img_v [16];
  int flt_v [9];
  logic [DW-1:0] exp_q [$];
  logic [9:0]    exp_addr_q [$];
  int            exp_tap_q [$];   // image address * 64 + filter address

  task automatic build_model();
    exp_q.delete();
    exp_addr_q.delete();
    exp_tap_q.delete();
    for (int i = 0; i < 16; i++) img_mem[i] = DW'(img_v[i]);
    for (int i = 0; i < 9; i++) flt_mem[i] = FW'(flt_v[i]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            s += img_v[(r + ky) * 4 + c + kx] * flt_v[ky * 3 + kx];
            exp_tap_q.push_back(((r + ky) * 4 + c + kx) * 64 + ky * 3 + kx);
          end
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q.push_back(DW'(s));
        exp_addr_q.push_back(10'(r * 2 + c));
      end
  endtask

  task automatic set_ramp(input int fval);
    for (int i = 0; i < 16; i++) img_v[i] = i;
    for (int i = 0; i < 9; i++) flt_v[i] = fval;
  endtask

  // ---------------- pass driver with per-cycle checks on DUT A ----------
  // rdy_mode: 0 always ready, 1 stall 20 cycles after first result, 2 random
  int pass_taps, pass_dones, pass_results;

  task automatic run_pass(input int rdy_mode, input int abort_at, input bit poke);
    int mac_cnt = 0, tap_in_win = 0, bp_left = 0, prev_tap = -1, post = 0, lat, t;
    int tap0_q [$];
    bit cap_pend = 0, done_seen = 0, first_seen = 0;
    logic [DW-1:0] ed;
    logic [9:0] ea;
    pass_taps = 0;
    pass_dones = 0;
    pass_results = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (poke) start = (n == 6 || n == 25);
      total++;
      if (busy !== !done_seen) begin
        bad++; $display("FAIL busy: got %b want %b (cycle %0d)", busy, !done_seen, n);
      end
      if (done) begin
        pass_dones++;
        done_seen = 1;
        total++;
        if (result_valid !== 1'b1) begin
          bad++; $display("FAIL done_result_valid: got %b want 1", result_valid);
        end
      end
      total++;
      if (img_rd_en !== flt_rd_en) begin
        bad++; $display("FAIL rd_en_pair: img %b flt %b", img_rd_en, flt_rd_en);
      end
      total++;
      if (mac_en) begin
        if (prev_tap < 0 || img_dout !== img_mem[prev_tap / 64] ||
            flt_dout !== flt_mem[prev_tap % 64]) begin
          bad++; $display("FAIL mac_data: got %h/%h for tap code %0d", img_dout, flt_dout, prev_tap);
        end
      end else if (img_dout !== '0 || flt_dout !== '0) begin
        bad++; $display("FAIL idle_data: got %h/%h want 0/0", img_dout, flt_dout);
      end
      if (cap_pend) begin
        lat = (tap0_q.size() > 0) ? n - tap0_q.pop_front() : -1;
        total++;
        if (result_valid !== 1'b1 || lat != 10) begin
          bad++; $display("FAIL latency: valid %b latency %0d want 1 and 10", result_valid, lat);
        end
      end
      cap_pend = one_done;
      if (mac_en) begin
        mac_cnt++;
        if (one_done) begin
          total++;
          if (mac_cnt != 9) begin
            bad++; $display("FAIL last_tap_pos: got tap %0d want 9", mac_cnt);
          end
          mac_cnt = 0;
        end
      end else begin
        total++;
        if (one_done !== 1'b0 || mac_cnt != 0) begin
          bad++; $display("FAIL mac_gap: oneConvDone %b after %0d taps", one_done, mac_cnt);
        end
        mac_cnt = 0;
      end
      prev_tap = -1;
      if (img_rd_en) begin
        total++;
        if (exp_tap_q.size() == 0) begin
          bad++; $display("FAIL tap_extra: addr %0d/%0d", img_addr, flt_addr);
        end else begin
          t = exp_tap_q.pop_front();
          if (img_addr !== 10'(t / 64) || flt_addr !== 6'(t % 64)) begin
            bad++; $display("FAIL tap_addr: got %0d/%0d want %0d/%0d", img_addr, flt_addr, t / 64, t % 64);
          end
          prev_tap = t;
        end
        total++;
        if (result_valid !== 1'b0) begin
          bad++; $display("FAIL tap_while_full: result_valid %b want 0", result_valid);
        end
        if (tap_in_win == 0) tap0_q.push_back(n);
        tap_in_win = (tap_in_win + 1) % 9;
        pass_taps++;
        if (abort_at >= 0 && pass_taps - 1 == abort_at) begin
          reset = 1'b1;
          return;
        end
      end
      if (rdy_mode == 1) begin
        if (result_valid && !first_seen) begin
          first_seen = 1;
          bp_left = 20;
        end
        result_ready = (bp_left == 0);
        if (bp_left > 0) bp_left--;
      end else if (rdy_mode == 2) begin
        result_ready = 1'($urandom_range(0, 1));
      end else begin
        result_ready = 1'b1;
      end
      if (result_valid && result_ready) begin
        pass_results++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL result_extra: got %0d at %0d", $signed(result_data), result_addr);
        end else begin
          ed = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          if (result_data !== ed || result_addr !== ea) begin
            bad++; $display("FAIL result: got %0d at %0d want %0d at %0d",
                            $signed(result_data), result_addr, $signed(ed), ea);
          end
        end
      end
      if (done_seen) post++;
      if (done_seen && exp_q.size() == 0 && post > 8) break;
    end
    start = 1'b0;
    result_ready = 1'b1;
    total++;
    if (!done_seen || exp_q.size() != 0) begin
      bad++; $display("FAIL pass_timeout: done %b results left %0d", done_seen, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    set_ramp(1);
    build_model();
    run_pass(0, -1, 1'b0);
    total++;
    if (pass_taps != 36 || pass_dones != 1 || pass_results != 4) begin
      bad++; $display("FAIL ramp_counts: taps %0d dones %0d results %0d want 36 1 4",
                      pass_taps, pass_dones, pass_results);
    end
  endtask

  task automatic test_backpressure();
    set_ramp(1);
    build_model();
    run_pass(1, -1, 1'b0);
    total++;
    if (pass_taps != 36 || pass_dones != 1 || pass_results != 4) begin
      bad++; $display("FAIL bp_counts: taps %0d dones %0d results %0d want 36 1 4",
                      pass_taps, pass_dones, pass_results);
    end
  endtask

  task automatic test_reset_mid_window();
    set_ramp(1);
    build_model();
    run_pass(0, 13, 1'b0);
    total++;
    if (pass_taps != 14) begin
      bad++; $display("FAIL abort_point: taps %0d want 14", pass_taps);
    end
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
    build_model();
    run_pass(0, -1, 1'b0);
    total++;
    if (pass_taps != 36 || pass_dones != 1 || pass_results != 4) begin
      bad++; $display("FAIL restart_counts: taps %0d dones %0d results %0d want 36 1 4",
                      pass_taps, pass_dones, pass_results);
    end
  endtask

  task automatic test_negative();
    set_ramp(-1);
    build_model();
    run_pass(0, -1, 1'b0);
    total++;
    if (pass_results != 4) begin
      bad++; $display("FAIL neg_counts: results %0d want 4", pass_results);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 16; i++) img_v[i] = int'($urandom_range(0, 100)) - 50;
      for (int i = 0; i < 9; i++) flt_v[i] = int'($urandom_range(0, 15)) - 8;
      build_model();
      run_pass(2, -1, 1'b0);
      total++;
      if (pass_taps != 36 || pass_dones != 1 || pass_results != 4) begin
        bad++; $display("FAIL random_counts: taps %0d dones %0d results %0d want 36 1 4",
                        pass_taps, pass_dones, pass_results);
      end
    end
  endtask

  task automatic test_start_while_busy();
    set_ramp(1);
    build_model();
    run_pass(0, -1, 1'b1);
    total++;
    if (pass_taps != 36 || pass_dones != 1 || pass_results != 4) begin
      bad++; $display("FAIL busy_start_counts: taps %0d dones %0d results %0d want 36 1 4",
                      pass_taps, pass_dones, pass_results);
    end
    repeat (10) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || img_rd_en !== 1'b0) begin
        bad++; $display("FAIL busy_start_idle: busy %b rd_en %b want 0 0", busy, img_rd_en);
      end
    end
  endtask

  task automatic test_ksize1();
    logic [DW-1:0] e1_q [$];
    int k = 0, n_res = 0, n_done = 0, v;
    logic [DW-1:0] ed;
    for (int i = 0; i < 9; i++) begin
      v = int'($urandom_range(0, 40));
      img1_mem[i] = DW'(v);
      e1_q.push_back(DW'(2 * v));
    end
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (mac_en1 || one_done1) begin
        total++;
        if (mac_en1 !== 1'b1 || one_done1 !== 1'b1) begin
          bad++; $display("FAIL k1_last_tap: macEnable %b oneConvDone %b want 1 1", mac_en1, one_done1);
        end
      end
      if (img_rd_en1) begin
        total++;
        if (img_addr1 !== 10'(k) || flt_addr1 !== 6'd0) begin
          bad++; $display("FAIL k1_addr: got %0d/%0d want %0d/0", img_addr1, flt_addr1, k);
        end
        k++;
      end
      if (result_valid1) begin
        total++;
        if (e1_q.size() == 0) begin
          bad++; $display("FAIL k1_extra: got %0d", result_data1);
        end else begin
          ed = e1_q.pop_front();
          if (result_data1 !== ed || result_addr1 !== 10'(n_res)) begin
            bad++; $display("FAIL k1_result: got %0d at %0d want %0d at %0d",
                            result_data1, result_addr1, ed, n_res);
          end
        end
        n_res++;
      end
      if (done1) n_done++;
    end
    total++;
    if (n_done != 1 || n_res != 9 || k != 9) begin
      bad++; $display("FAIL k1_counts: dones %0d results %0d taps %0d want 1 9 9", n_done, n_res, k);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_reset_mid_window();
    test_ksize1();
    test_negative();
    test_random();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
